// File: rtl/laser_pattern_driver.sv
// rtl/laser_pattern_driver.sv - host point buffer, point streamer and circle-coverage scorer for the LASER engine
// Define LASER_DRV_SCORE_EN to build the SCORE state and coverage datapath; otherwise COVER is tied to 0.
module laser_pattern_driver #(
  parameter int NUM_PTS   = 40,
  parameter int RADIUS_SQ = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        WR_EN,
  input  logic [5:0]  WR_ADDR,
  input  logic [3:0]  WR_X,
  input  logic [3:0]  WR_Y,
  input  logic        START,
  output logic        BUSY,
  output logic [3:0]  X,
  output logic [3:0]  Y,
  input  logic        DONE,
  input  logic [3:0]  C1X,
  input  logic [3:0]  C1Y,
  input  logic [3:0]  C2X,
  input  logic [3:0]  C2Y,
  output logic [15:0] RES_C,
  output logic [5:0]  COVER,
  output logic        RES_VALID,
  output logic        TIMEOUT_ERR
);

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [5:0]      LAST_IDX = 6'(NUM_PTS - 1);
  localparam logic [5:0]      NUM_P    = 6'(NUM_PTS);
  localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT - 1);

  if (NUM_PTS < 1 || NUM_PTS > 63 || RADIUS_SQ < 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("laser_pattern_driver: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_STREAM,
    S_WAIT_LOW,
    S_WAIT_RES,
`ifdef LASER_DRV_SCORE_EN
    S_SCORE,
`endif
    S_REPORT
  } state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic [3:0]    x_q, x_d;
  logic [3:0]    y_q, y_d;
  logic [15:0]   res_c_q, res_c_d;
  logic          res_valid_q, res_valid_d;
  logic          timeout_err_q, timeout_err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    idx_q, idx_d;

  // Point buffer is deliberately left out of reset so a reset does not force a reload.
  logic [7:0] pts_mem [0:63];
  logic       wr_ok;
  logic [5:0] idx_inc;
  logic [7:0] first_pt;
  logic [7:0] next_pt;
  logic       wait_tick;

  assign wr_ok    = WR_EN && (state_q == S_IDLE) && (WR_ADDR < NUM_P);
  assign idx_inc  = idx_q + 6'd1;
  assign first_pt = pts_mem[6'd0];
  assign next_pt  = pts_mem[idx_inc];

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      pts_mem[WR_ADDR] <= {WR_X, WR_Y};
    end
  end

`ifdef LASER_DRV_SCORE_EN
  localparam logic [9:0] RSQ = 10'(RADIUS_SQ);

  logic [5:0] acc_q, acc_d;
  logic [5:0] cover_q, cover_d;
  logic [7:0] score_pt;
  logic [8:0] dist1, dist2;
  logic       hit;
  logic [5:0] acc_next;

  function automatic logic [8:0] dist_sq(input logic [3:0] px, input logic [3:0] py,
                                         input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [7:0] sx, sy;
    dx = (px >= cx) ? (px - cx) : (cx - px);
    dy = (py >= cy) ? (py - cy) : (cy - py);
    sx = {4'd0, dx} * {4'd0, dx};
    sy = {4'd0, dy} * {4'd0, dy};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

  assign score_pt = pts_mem[idx_q];
  assign dist1    = dist_sq(score_pt[7:4], score_pt[3:0], res_c_q[15:12], res_c_q[11:8]);
  assign dist2    = dist_sq(score_pt[7:4], score_pt[3:0], res_c_q[7:4], res_c_q[3:0]);
  assign hit      = ({1'b0, dist1} <= RSQ) || ({1'b0, dist2} <= RSQ);
  assign acc_next = (hit && (acc_q != 6'd63)) ? (acc_q + 6'd1) : acc_q;
  assign COVER    = cover_q;
`else
  assign COVER    = 6'd0;
`endif

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    x_d           = x_q;
    y_d           = y_q;
    res_c_d       = res_c_q;
    res_valid_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    timer_d       = timer_q;
    idx_d         = idx_q;
    wait_tick     = 1'b0;
`ifdef LASER_DRV_SCORE_EN
    acc_d         = acc_q;
    cover_d       = cover_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d       = S_WAIT_RDY;
          busy_d        = 1'b1;
          timeout_err_d = 1'b0;
          timer_d       = '0;
        end
      end
      S_WAIT_RDY: begin
        if (DONE) begin
          state_d = S_STREAM;
          idx_d   = 6'd0;
          x_d     = first_pt[7:4];
          y_d     = first_pt[3:0];
        end else begin
          wait_tick = 1'b1;
        end
      end
      S_STREAM: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_WAIT_LOW;
          x_d     = 4'd0;
          y_d     = 4'd0;
          timer_d = '0;
        end else begin
          idx_d = idx_inc;
          x_d   = next_pt[7:4];
          y_d   = next_pt[3:0];
        end
      end
      // DONE must drop before a new high is trusted as the result.
      S_WAIT_LOW: begin
        if (!DONE) begin
          state_d = S_WAIT_RES;
          timer_d = '0;
        end else begin
          wait_tick = 1'b1;
        end
      end
      S_WAIT_RES: begin
        if (DONE) begin
          res_c_d = {C1X, C1Y, C2X, C2Y};
`ifdef LASER_DRV_SCORE_EN
          state_d = S_SCORE;
          idx_d   = 6'd0;
          acc_d   = 6'd0;
`else
          state_d     = S_REPORT;
          res_valid_d = 1'b1;
`endif
        end else begin
          wait_tick = 1'b1;
        end
      end
`ifdef LASER_DRV_SCORE_EN
      S_SCORE: begin
        if (idx_q == LAST_IDX) begin
          cover_d     = acc_next;
          state_d     = S_REPORT;
          res_valid_d = 1'b1;
        end else begin
          acc_d = acc_next;
          idx_d = idx_inc;
        end
      end
`endif
      S_REPORT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (wait_tick) begin
      if (timer_q == T_LAST) begin
        state_d       = S_REPORT;
        res_valid_d   = 1'b1;
        timeout_err_d = 1'b1;
        res_c_d       = 16'd0;
`ifdef LASER_DRV_SCORE_EN
        cover_d       = 6'd0;
`endif
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      x_q           <= 4'd0;
      y_q           <= 4'd0;
      res_c_q       <= 16'd0;
      res_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      timer_q       <= '0;
      idx_q         <= 6'd0;
`ifdef LASER_DRV_SCORE_EN
      acc_q         <= 6'd0;
      cover_q       <= 6'd0;
`endif
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      x_q           <= x_d;
      y_q           <= y_d;
      res_c_q       <= res_c_d;
      res_valid_q   <= res_valid_d;
      timeout_err_q <= timeout_err_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
`ifdef LASER_DRV_SCORE_EN
      acc_q         <= acc_d;
      cover_q       <= cover_d;
`endif
    end
  end

  assign BUSY        = busy_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign RES_C       = res_c_q;
  assign RES_VALID   = res_valid_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_laser_pattern_driver.sv
// tb/tb_laser_pattern_driver.sv - directed self-checking bench for laser_pattern_driver
module tb_laser_pattern_driver;

  localparam int NUM_PTS = 40;
  localparam int TIMEOUT = 4096;
`ifdef LASER_DRV_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        WR_EN = 1'b0;
  logic [5:0]  WR_ADDR = 6'd0;
  logic [3:0]  WR_X = 4'd0;
  logic [3:0]  WR_Y = 4'd0;
  logic        START = 1'b0;
  logic        DONE = 1'b1;
  logic [3:0]  C1X = 4'd0, C1Y = 4'd0, C2X = 4'd0, C2Y = 4'd0;
  logic        BUSY;
  logic [3:0]  X, Y;
  logic [15:0] RES_C;
  logic [5:0]  COVER;
  logic        RES_VALID;
  logic        TIMEOUT_ERR;

  int checks = 0;
  int errors = 0;
  logic [3:0] mx [0:NUM_PTS-1];
  logic [3:0] my [0:NUM_PTS-1];

  laser_pattern_driver #(.NUM_PTS(NUM_PTS), .RADIUS_SQ(16), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_X(WR_X), .WR_Y(WR_Y),
    .START(START), .BUSY(BUSY), .X(X), .Y(Y), .DONE(DONE),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .RES_C(RES_C), .COVER(COVER), .RES_VALID(RES_VALID), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [3:0] x, input logic [3:0] y);
    WR_EN = 1'b1; WR_ADDR = a; WR_X = x; WR_Y = y;
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic run_frame(input logic [3:0] c1x, input logic [3:0] c1y,
                           input logic [3:0] c2x, input logic [3:0] c2y,
                           input int cov, input bit inj, input bit sw,
                           input logic [3:0] swx, input logic [3:0] swy);
    int cnt;
    int lat;
    lat = SCORE_EN ? NUM_PTS + 1 : 1;
    DONE  = 1'b1;
    START = 1'b1;
    if (sw) begin
      WR_EN = 1'b1; WR_ADDR = 6'd0; WR_X = swx; WR_Y = swy;
      mx[0] = swx; my[0] = swy;
    end
    @(negedge CLK);
    START = 1'b0; WR_EN = 1'b0;
    check("busy_after_start", BUSY, 1);
    check("terr_cleared", TIMEOUT_ERR, 0);
    for (int k = 0; k < NUM_PTS; k++) begin
      @(negedge CLK);
      check($sformatf("stream_xy[%0d]", k), {X, Y}, {mx[k], my[k]});
      check($sformatf("no_early_valid[%0d]", k), RES_VALID, 0);
      if (k == 0) DONE = 1'b0;
      if (inj && k == 5) begin
        START = 1'b1; WR_EN = 1'b1; WR_ADDR = 6'd3; WR_X = 4'd7; WR_Y = 4'd7;
      end else begin
        START = 1'b0; WR_EN = 1'b0;
      end
    end
    @(negedge CLK);
    check("xy_zero_after_stream", {X, Y}, 8'h00);
    @(negedge CLK);
    DONE = 1'b1; C1X = c1x; C1Y = c1y; C2X = c2x; C2Y = c2y;
    cnt = 0;
    do begin
      @(negedge CLK);
      cnt++;
    end while (!RES_VALID && cnt < 200);
    check("res_latency", cnt, lat);
    check("res_c", RES_C, {c1x, c1y, c2x, c2y});
    check("cover", COVER, SCORE_EN ? cov : 0);
    check("terr_normal", TIMEOUT_ERR, 0);
    @(negedge CLK);
    check("valid_one_cycle", RES_VALID, 0);
    check("busy_end", BUSY, 0);
  endtask

  initial begin
    int cnt;
    repeat (2) @(negedge CLK);
    check("rst_busy", BUSY, 0);
    check("rst_xy", {X, Y}, 8'h00);
    check("rst_res_c", RES_C, 0);
    check("rst_cover", COVER, 0);
    check("rst_valid", RES_VALID, 0);
    check("rst_terr", TIMEOUT_ERR, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Frame 1: all points at (5,5)
    for (int k = 0; k < NUM_PTS; k++) begin
      wr(6'(k), 4'd5, 4'd5);
      mx[k] = 4'd5; my[k] = 4'd5;
    end
    run_frame(4'd5, 4'd5, 4'd10, 4'd10, 40, 1'b0, 1'b0, 4'd0, 4'd0);
    check("res_c_55aa", RES_C, 16'h55AA);

    // Frame 2: (0,0) at dist^2 16 from C1 covered, (9,0) at 25 not covered; START/WR injected mid-stream
    for (int k = 0; k < NUM_PTS; k++) begin
      if (k % 2 == 0) begin
        wr(6'(k), 4'd0, 4'd0); mx[k] = 4'd0; my[k] = 4'd0;
      end else begin
        wr(6'(k), 4'd9, 4'd0); mx[k] = 4'd9; my[k] = 4'd0;
      end
    end
    run_frame(4'd4, 4'd0, 4'd15, 4'd15, 20, 1'b1, 1'b0, 4'd0, 4'd0);
    wr(6'd45, 4'd1, 4'd1);
    run_frame(4'd4, 4'd0, 4'd15, 4'd15, 20, 1'b0, 1'b0, 4'd0, 4'd0);

    // Timeout: DONE stays low after the stream
    DONE = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int k = 0; k < NUM_PTS; k++) begin
      @(negedge CLK);
      if (k == 0) DONE = 1'b0;
    end
    cnt = 0;
    do begin
      @(negedge CLK);
      cnt++;
    end while (!RES_VALID && cnt < TIMEOUT + 50);
    check("timeout_latency", cnt, TIMEOUT + 2);
    check("timeout_err", TIMEOUT_ERR, 1);
    check("timeout_res_c", RES_C, 0);
    check("timeout_cover", COVER, 0);
    @(negedge CLK);
    check("timeout_busy", BUSY, 0);
    check("timeout_valid_drop", RES_VALID, 0);
    check("timeout_sticky", TIMEOUT_ERR, 1);

    // Write committed in the START cycle; (8,8) is outside both circles
    run_frame(4'd4, 4'd0, 4'd15, 4'd15, 19, 1'b0, 1'b1, 4'd8, 4'd8);

    // Reset at stream cycle 10
    DONE = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (k == 0) DONE = 1'b0;
    end
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_xy", {X, Y}, 8'h00);
    check("mid_rst_res_c", RES_C, 0);
    check("mid_rst_cover", COVER, 0);
    check("mid_rst_valid", RES_VALID, 0);
    check("mid_rst_terr", TIMEOUT_ERR, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("mid_rst_no_valid", RES_VALID, 0);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    check("post_rst_valid", RES_VALID, 0);
    run_frame(4'd4, 4'd0, 4'd15, 4'd15, 19, 1'b0, 1'b0, 4'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
